// File: rtl/mod_pkg.sv
// Shared definitions for the modulus control unit and its datapath.
package mod_pkg;

  localparam int unsigned MOD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SUBTRACT = 2'b01,
    ST_RESULT   = 2'b10,
    ST_RSVD     = 2'b11
  } mod_state_e;

endpackage

// File: rtl/mod_dp.sv
// Modulus datapath: repeated subtraction driven by the control unit's state code,
// returning the running difference and registering remainder/quotient on RESULT.
module mod_dp
  import mod_pkg::*;
#(
  parameter int unsigned WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       state,
  input  logic [WIDTH-2:0] dividend,
  input  logic [WIDTH-2:0] divisor,
  output logic [WIDTH-1:0] temp,
  output logic [WIDTH-2:0] result,
  output logic [WIDTH-2:0] quotient,
  output logic             div_by_zero,
  output logic             done
);

  mod_state_e st;

  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-2:0] div_q, div_d;
  logic [WIDTH-2:0] dvd_q, dvd_d;
  logic [WIDTH-2:0] result_q, result_d;
  logic [WIDTH-2:0] quot_q, quot_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] diff;
  logic [WIDTH-2:0] sum_lo;
  logic [WIDTH-2:0] cnt_m1_lo;

  assign st = mod_state_e'(state);

  assign diff      = temp_q - {1'b0, div_q};
  // Only the low WIDTH-1 bits of the restore-add and of cnt-1 are ever used.
  assign sum_lo    = temp_q[WIDTH-2:0] + div_q;
  assign cnt_m1_lo = cnt_q[WIDTH-2:0] - (WIDTH-1)'(1);

  always_comb begin
    temp_d   = temp_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    dvd_d    = dvd_q;
    result_d = result_q;
    quot_d   = quot_q;
    dbz_d    = dbz_q;
    done_d   = (st == ST_RESULT);
    unique case (st)
      ST_SUBTRACT: begin
        if (div_q == '0) begin
          temp_d = '1;
        end else if (!temp_q[WIDTH-1]) begin
          temp_d = diff;
          cnt_d  = cnt_q + WIDTH'(1);
        end
      end
      ST_RESULT: begin
        if (div_q == '0) begin
          result_d = dvd_q;
          quot_d   = '0;
          dbz_d    = 1'b1;
        end else if (cnt_q == '0) begin
          result_d = temp_q[WIDTH-2:0];
          quot_d   = '0;
          dbz_d    = 1'b0;
        end else if (temp_q[WIDTH-1]) begin
          result_d = sum_lo;
          quot_d   = cnt_m1_lo;
          dbz_d    = 1'b0;
        end else begin
          result_d = temp_q[WIDTH-2:0];
          quot_d   = cnt_q[WIDTH-2:0];
          dbz_d    = 1'b0;
        end
      end
      default: begin
        temp_d = {1'b0, dividend};
        div_d  = divisor;
        dvd_d  = dividend;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      temp_q   <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      dvd_q    <= '0;
      result_q <= '0;
      quot_q   <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      temp_q   <= temp_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      dvd_q    <= dvd_d;
      result_q <= result_d;
      quot_q   <= quot_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign temp        = temp_q;
  assign result      = result_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mod_dp.sv
// Self-checking bench for mod_dp: vector table, randomized operations against an
// arithmetic model, and hand-written reset / operand-change / max-count sequences.
module tb_mod_dp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  st32, st8;
  logic [30:0] a32, b32;
  logic [6:0]  a8, b8;
  logic [31:0] temp32;
  logic [30:0] res32, quo32;
  logic        dbz32, done32;
  logic [7:0]  temp8;
  logic [6:0]  res8, quo8;
  logic        dbz8, done8;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_dp #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .state(st32), .dividend(a32), .divisor(b32),
    .temp(temp32), .result(res32), .quotient(quo32),
    .div_by_zero(dbz32), .done(done32)
  );

  mod_dp #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .state(st8), .dividend(a8), .divisor(b8),
    .temp(temp8), .result(res8), .quotient(quo8),
    .div_by_zero(dbz8), .done(done8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected running difference after k SUBTRACT cycles, from the arithmetic
  // definition: subtraction stops once the value first goes negative.
  function automatic logic [31:0] exp_temp(input logic [30:0] a, input logic [30:0] b,
                                            input int k);
    longint q1, keff;
    if (b == 0) return 32'hFFFF_FFFF;
    q1   = longint'(a) / longint'(b) + 1;
    keff = (longint'(k) < q1) ? longint'(k) : q1;
    return 32'(longint'(a) - keff * longint'(b));
  endfunction

  task automatic run_op(input string nm, input logic [30:0] a, input logic [30:0] b,
                        input int nsub, input int nres, input bit change,
                        input logic [30:0] er, input logic [30:0] eq, input logic edbz);
    logic [30:0] prev_r;
    prev_r = res32;
    st32 = 2'b00; a32 = a; b32 = b;
    step();
    chk({nm, ".idle_temp"}, temp32, {1'b0, a});
    chk({nm, ".idle_hold"}, res32, prev_r);
    chk({nm, ".idle_done"}, done32, 1'b0);
    st32 = 2'b01;
    for (int k = 1; k <= nsub; k++) begin
      if (change && k == 2) begin a32 = 31'd100; b32 = 31'd1; end
      step();
      chk({nm, ".sub_temp"}, temp32, exp_temp(a, b, k));
      chk({nm, ".sub_done"}, done32, 1'b0);
    end
    st32 = 2'b10;
    for (int k = 0; k < nres; k++) begin
      step();
      chk({nm, ".res"}, res32, er);
      chk({nm, ".quo"}, quo32, eq);
      chk({nm, ".dbz"}, dbz32, edbz);
      chk({nm, ".done"}, done32, 1'b1);
    end
    st32 = 2'b00;
    step();
    chk({nm, ".done_drop"}, done32, 1'b0);
    chk({nm, ".res_hold"}, res32, er);
  endtask

  typedef struct {
    string       nm;
    logic [30:0] a, b;
    int          nsub, nres;
    bit          change;
    logic [30:0] er, eq;
    logic        edbz;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [30:0] ra, rb, rq, rr;
    int rn;

    vecs.push_back('{"a12b4",   31'd12, 31'd4, 6, 1, 1'b0, 31'd0,  31'd3, 1'b0});
    vecs.push_back('{"a3b5",    31'd3,  31'd5, 2, 1, 1'b0, 31'd3,  31'd0, 1'b0});
    vecs.push_back('{"a0b7",    31'd0,  31'd7, 2, 1, 1'b0, 31'd0,  31'd0, 1'b0});
    vecs.push_back('{"b0a9",    31'd9,  31'd0, 2, 1, 1'b0, 31'd9,  31'd0, 1'b1});
    vecs.push_back('{"a10b3",   31'd10, 31'd3, 4, 1, 1'b0, 31'd1,  31'd3, 1'b0});
    vecs.push_back('{"chg",     31'd20, 31'd6, 5, 1, 1'b1, 31'd2,  31'd3, 1'b0});
    vecs.push_back('{"skip",    31'd5,  31'd2, 0, 1, 1'b0, 31'd5,  31'd0, 1'b0});
    vecs.push_back('{"res3x",   31'd29, 31'd4, 9, 3, 1'b0, 31'd1,  31'd7, 1'b0});
    vecs.push_back('{"exact",   31'd21, 31'd7, 4, 1, 1'b0, 31'd0,  31'd3, 1'b0});

    reset = 1'b0; st32 = 2'b01; st8 = 2'b00;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    step(); step();
    chk("por_temp", temp32, 0);
    chk("por_res", res32, 0);
    chk("por_quo", quo32, 0);
    chk("por_dbz", dbz32, 0);
    chk("por_done", done32, 0);
    reset = 1'b1; st32 = 2'b00;
    step();

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].nsub, vecs[i].nres,
             vecs[i].change, vecs[i].er, vecs[i].eq, vecs[i].edbz);

    // Reserved code 11 behaves as IDLE: it must load operands.
    st32 = 2'b11; a32 = 31'd77; b32 = 31'd5;
    step();
    chk("st11_temp", temp32, 32'd77);
    chk("st11_done", done32, 0);

    // Reset mid-SUBTRACT with a nonzero running difference and a nonzero result.
    run_op("pre", 31'd17, 31'd5, 4, 1, 1'b0, 31'd2, 31'd3, 1'b0);
    st32 = 2'b00; a32 = 31'd40; b32 = 31'd3;
    step();
    st32 = 2'b01;
    step(); step();
    chk("mid_temp_nz", temp32, 32'd34);
    reset = 1'b0;
    step();
    chk("rst_temp", temp32, 0);
    chk("rst_res", res32, 0);
    chk("rst_quo", quo32, 0);
    chk("rst_dbz", dbz32, 0);
    chk("rst_done", done32, 0);
    step();
    chk("rst2_temp", temp32, 0);
    reset = 1'b1;
    run_op("post", 31'd10, 31'd3, 4, 1, 1'b0, 31'd1, 31'd3, 1'b0);

    // Randomized operations against the division model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rb = '0;
        ra = 31'($urandom);
        rn = 1 + $urandom_range(0, 2);
        run_op("rnd_dbz", ra, rb, rn, 1, 1'b0, ra, 31'd0, 1'b1);
      end else begin
        rb = 31'($urandom_range(1, 1000));
        rq = 31'($urandom_range(0, 40));
        rr = 31'($urandom_range(0, 999)) % rb;
        ra = rb * rq + rr;
        rn = int'(ra / rb) + 1 + $urandom_range(0, 2);
        run_op("rnd", ra, rb, rn, 1, $urandom_range(0, 3) == 0, ra % rb, ra / rb, 1'b0);
      end
    end

    // Largest count, on an 8-bit instance: A = 2^7-1, B = 1.
    st32 = 2'b00;
    st8 = 2'b00; a8 = 7'd127; b8 = 7'd1;
    step();
    st8 = 2'b01;
    for (int k = 0; k < 130; k++) step();
    chk("max_temp", temp8, 8'hFF);
    st8 = 2'b10;
    step();
    chk("max_quo", quo8, 7'd127);
    chk("max_res", res8, 7'd0);
    chk("max_dbz", dbz8, 1'b0);
    chk("max_done", done8, 1'b1);
    st8 = 2'b00;
    step();
    chk("max_done_drop", done8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
